mem_dma: RTL and testbench
==========================

MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameter READ_WAIT, default 2, is the number of cycles MREAD and the source address are held before read_data is captured; legal values are 1 or more.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-004 start  input  1  request a copy; sampled only in IDLE.
REQ-005 src  input  9  source start address; sampled with start.
REQ-006 dst  input  9  destination start address; sampled with start.
REQ-007 len  input  9  number of 16-bit words to copy (0-511); sampled with start.
REQ-008 read_data  input  16  data returned by the memory/IO bus.
REQ-009 mem_cmd  output  2  bus command: 2'b00 none, 2'b01 read, 2'b10 write (2'b11 never driven).
REQ-010 mem_addr  output  9  bus address.
REQ-011 write_data  output  16  bus write data.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at completion.
REQ-014 remaining  output  9  words still to be copied.

Function
REQ-015 The block SHALL be a bus initiator on the same command/address/data protocol as the CPU:
- addr[8]=0 selects RAM.
- 9'h100 is the LED register (write).
- 9'h140 is the switch port (read).
REQ-016 States:
- IDLE
- RD (lasts READ_WAIT cycles)
- WR (lasts 1 cycle)
- FIN (lasts 1 cycle)
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL latch src, dst and len into internal pointers and remaining.
- If len≠0, the next state SHALL be RD.
- If len=0, the next state SHALL be FIN.
REQ-018 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 In RD: mem_cmd=01 and mem_addr=source pointer, held constant for READ_WAIT consecutive cycles.
REQ-021 On the edge ending the last RD cycle, read_data SHALL be captured into the data register and the next state SHALL be WR.
REQ-022 In WR: mem_cmd=10, mem_addr=destination pointer, write_data=data register, for exactly one cycle.
REQ-023 On the edge ending WR:
- source pointer +1, destination pointer +1, remaining −1;
- if remaining becomes 0, next state FIN, otherwise next state RD.
REQ-024 Pointer arithmetic SHALL be 9-bit modulo 512, so 9'h1FF+1 wraps to 9'h000 with no error flag.
REQ-025 In FIN, done=1 and mem_cmd=00 for one cycle, and the next state SHALL be IDLE.
REQ-026 In IDLE and FIN: mem_cmd=00 and mem_addr=9'h000.
REQ-027 write_data SHALL always equal the data register.
REQ-028 Each word SHALL take READ_WAIT+1 cycles.
REQ-029 For len=N≥1 with start sampled at edge 0, done SHALL be high during cycle N*(READ_WAIT+1)+1.
REQ-030 For len=0, done SHALL be high in cycle 1 and the bus SHALL see no command.
REQ-031 The copy SHALL be forward-only with no overlap handling; if dst=src+1 the first word is replicated (defined behaviour).
REQ-032 read_data SHALL be captured unconditionally, so X on the bus propagates into the copied data without any special handling.

Reset
REQ-033 While reset=0, the block SHALL hold: state=IDLE, mem_cmd=00, mem_addr=0, write_data=0, busy=0, done=0, remaining=0, with pointers and data register cleared.
REQ-034 Reset asserted mid-transfer SHALL abort immediately: no further bus command, no done pulse, and any partially copied data is left in place.
REQ-035 After reset deasserts, the block SHALL resume in IDLE and accept start on the first rising edge.

Verification
REQ-036 RAM[0x10..0x12]=0xAAAA,0x5555,0x1234; start with src=0x10, dst=0x20, len=3 -> RAM[0x20..0x22] match the source, done pulses in cycle 10, and remaining goes 3→2→1→0.
REQ-037 start with len=0 -> done pulses in cycle 1, busy is high for 1 cycle, mem_cmd stays 00 throughout.
REQ-038 SW=8'h5A; start with src=0x140, dst=0x100, len=1 -> LEDR[7:0]=0x5A, and write_data=0x005A during WR.
REQ-039 start with src=0x1FF, dst=0x0FE, len=2 -> reads from 0x1FF then 0x000, writes to 0x0FE then 0x0FF.
REQ-040 start with len=4, then reset=0 during the second RD -> mem_cmd=00 and busy=0 immediately with no done pulse; after release, start with len=1 completes normally.
REQ-041 start held high through an entire transfer -> a second transfer starts only from IDLE after FIN, with the inputs re-sampled at that point.

Source files
------------

// File: rtl/mem_dma.sv
// Bus-initiator DMA engine: copies len 16-bit words from src to dst over the
// shared command/address/data bus, one READ_WAIT-cycle read then one write per word.
module mem_dma #(
    parameter int unsigned READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  src,
    input  logic [8:0]  dst,
    input  logic [8:0]  len,
    input  logic [15:0] read_data,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [8:0]  remaining
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_src;
    logic [8:0]  r_dst;
    logic [8:0]  r_rem;
    logic [15:0] r_data;
    logic [31:0] r_wait;
    logic        w_last_rd;

    // r_wait counts completed RD cycles; the last one is when it reaches READ_WAIT-1
    assign w_last_rd  = (r_wait == READ_WAIT - 1);
    assign write_data = r_data;
    assign remaining  = r_rem;

    always_comb begin
        w_next   = r_state;
        mem_cmd  = CMD_NONE;
        mem_addr = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (len == 9'd0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                mem_cmd  = CMD_READ;
                mem_addr = r_src;
                if (w_last_rd) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                mem_cmd  = CMD_WRITE;
                mem_addr = r_dst;
                w_next   = (r_rem == 9'd1) ? S_FIN : S_RD;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src  <= src;
                        r_dst  <= dst;
                        r_rem  <= len;
                        r_wait <= '0;
                    end
                end
                S_RD: begin
                    if (w_last_rd) begin
                        r_data <= read_data;
                        r_wait <= '0;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                S_WR: begin
                    r_src <= r_src + 9'd1;
                    r_dst <= r_dst + 9'd1;
                    r_rem <= r_rem - 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a small RAM / LED / switch bus model behind it.
module tb_mem_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [8:0]  len;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic        busy;
    logic        done;
    logic [8:0]  remaining;

    int checks;
    int errors;

    logic [15:0] ram [0:255];
    logic [7:0]  led;
    logic [7:0]  sw;
    logic        pl_we;
    logic [7:0]  pl_a;
    logic [15:0] pl_d;

    logic [1:0]  log_cmd  [0:31];
    logic [8:0]  log_addr [0:31];
    logic [15:0] log_wd   [0:31];
    logic        log_done [0:31];
    logic        log_busy [0:31];
    logic [8:0]  log_rem  [0:31];

    mem_dma #(.READ_WAIT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .read_data  (read_data),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = !mem_addr[8] ? ram[mem_addr[7:0]] :
                       (mem_addr == 9'h140) ? {8'h00, sw} : 16'h0000;

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (mem_cmd == 2'b10) begin
            if (!mem_addr[8]) ram[mem_addr[7:0]] <= write_data;
            else if (mem_addr == 9'h100) led <= write_data[7:0];
        end
    end

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // Start sampled at edge 0; cycle c is logged at the falling edge after edge c-1.
    task automatic run_xfer(input logic [8:0] s, input logic [8:0] d,
                            input logic [8:0] l, input int n);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            log_cmd[c] = mem_cmd; log_addr[c] = mem_addr; log_wd[c] = write_data;
            log_done[c] = done; log_busy[c] = busy; log_rem[c] = remaining;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_cmd, mem_addr, write_data, busy, done, remaining} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got cmd=%b addr=%h wd=%h busy=%b done=%b rem=%h exp all zero",
                     mem_cmd, mem_addr, write_data, busy, done, remaining);
        end
        reset = 1'b1;
    endtask

    task automatic test_copy3;
        int dc;
        int nd;
        poke(8'h10, 16'hAAAA);
        poke(8'h11, 16'h5555);
        poke(8'h12, 16'h1234);
        run_xfer(9'h010, 9'h020, 9'd3, 12);
        dc = 0; nd = 0;
        for (int c = 1; c <= 12; c++) if (log_done[c]) begin nd++; if (dc == 0) dc = c; end
        checks++;
        if (dc !== 10 || nd !== 1) begin
            errors++; $display("FAIL copy3_done got cycle=%0d pulses=%0d exp cycle=10 pulses=1", dc, nd);
        end
        checks++;
        if (log_cmd[1] !== 2'b01 || log_addr[1] !== 9'h010 || log_cmd[2] !== 2'b01 || log_addr[2] !== 9'h010) begin
            errors++; $display("FAIL copy3_rd got %b/%h %b/%h exp 01/010 01/010",
                               log_cmd[1], log_addr[1], log_cmd[2], log_addr[2]);
        end
        checks++;
        if (log_cmd[3] !== 2'b10 || log_addr[3] !== 9'h020 || log_wd[3] !== 16'hAAAA) begin
            errors++; $display("FAIL copy3_wr got %b/%h/%h exp 10/020/aaaa", log_cmd[3], log_addr[3], log_wd[3]);
        end
        checks++;
        if (log_rem[1] !== 9'd3 || log_rem[4] !== 9'd2 || log_rem[7] !== 9'd1 || log_rem[10] !== 9'd0) begin
            errors++; $display("FAIL copy3_remaining got %0d %0d %0d %0d exp 3 2 1 0",
                               log_rem[1], log_rem[4], log_rem[7], log_rem[10]);
        end
        checks++;
        if (ram[8'h20] !== 16'hAAAA || ram[8'h21] !== 16'h5555 || ram[8'h22] !== 16'h1234) begin
            errors++; $display("FAIL copy3_data got %h %h %h exp aaaa 5555 1234", ram[8'h20], ram[8'h21], ram[8'h22]);
        end
        checks++;
        if (log_busy[1] !== 1'b1 || log_busy[11] !== 1'b0 || log_cmd[10] !== 2'b00 || log_addr[10] !== 9'h000) begin
            errors++; $display("FAIL copy3_busy_fin got busy1=%b busy11=%b fin=%b/%h exp 1 0 00/000",
                               log_busy[1], log_busy[11], log_cmd[10], log_addr[10]);
        end
    endtask

    task automatic test_len0;
        int nb;
        int nc;
        run_xfer(9'h033, 9'h044, 9'd0, 3);
        nb = 0; nc = 0;
        for (int c = 1; c <= 3; c++) begin
            if (log_busy[c]) nb++;
            if (log_cmd[c] != 2'b00) nc++;
        end
        checks++;
        if (log_done[1] !== 1'b1 || log_done[2] !== 1'b0) begin
            errors++; $display("FAIL len0_done got %b%b exp 10", log_done[1], log_done[2]);
        end
        checks++;
        if (nb !== 1 || nc !== 0) begin
            errors++; $display("FAIL len0_bus got busy_cycles=%0d cmd_cycles=%0d exp 1 0", nb, nc);
        end
    endtask

    task automatic test_io;
        sw = 8'h5A;
        run_xfer(9'h140, 9'h100, 9'd1, 5);
        checks++;
        if (log_cmd[3] !== 2'b10 || log_addr[3] !== 9'h100 || log_wd[3] !== 16'h005A) begin
            errors++; $display("FAIL io_write got %b/%h/%h exp 10/100/005a", log_cmd[3], log_addr[3], log_wd[3]);
        end
        checks++;
        if (led !== 8'h5A || log_done[4] !== 1'b1) begin
            errors++; $display("FAIL io_led got led=%h done4=%b exp 5a 1", led, log_done[4]);
        end
    endtask

    task automatic test_wrap;
        poke(8'h00, 16'hBEEF);
        poke(8'hFE, 16'h1111);
        poke(8'hFF, 16'h2222);
        run_xfer(9'h1FF, 9'h0FE, 9'd2, 8);
        checks++;
        if (log_addr[1] !== 9'h1FF || log_addr[3] !== 9'h0FE || log_addr[4] !== 9'h000 || log_addr[6] !== 9'h0FF) begin
            errors++; $display("FAIL wrap_addr got %h %h %h %h exp 1ff 0fe 000 0ff",
                               log_addr[1], log_addr[3], log_addr[4], log_addr[6]);
        end
        checks++;
        if (ram[8'hFE] !== 16'h0000 || ram[8'hFF] !== 16'hBEEF || log_done[7] !== 1'b1) begin
            errors++; $display("FAIL wrap_data got %h %h done7=%b exp 0000 beef 1", ram[8'hFE], ram[8'hFF], log_done[7]);
        end
    endtask

    task automatic test_abort;
        int bad;
        poke(8'h30, 16'hC0DE);
        poke(8'h31, 16'hC0DF);
        poke(8'h40, 16'h0000);
        poke(8'h41, 16'h7777);
        run_xfer(9'h030, 9'h040, 9'd4, 4);
        checks++;
        if (log_cmd[4] !== 2'b01 || log_addr[4] !== 9'h031) begin
            errors++; $display("FAIL abort_second_rd got %b/%h exp 01/031", log_cmd[4], log_addr[4]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_cmd !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || remaining !== 9'd0 || mem_addr !== 9'h000) begin
            errors++; $display("FAIL abort_immediate got cmd=%b busy=%b done=%b rem=%h addr=%h exp 00 0 0 000 000",
                               mem_cmd, busy, done, remaining, mem_addr);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || mem_cmd !== 2'b00) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad);
        end
        checks++;
        if (ram[8'h40] !== 16'hC0DE || ram[8'h41] !== 16'h7777) begin
            errors++; $display("FAIL abort_partial got %h %h exp c0de 7777", ram[8'h40], ram[8'h41]);
        end
        reset = 1'b1;
        run_xfer(9'h031, 9'h041, 9'd1, 5);
        checks++;
        if (log_done[4] !== 1'b1 || ram[8'h41] !== 16'hC0DF) begin
            errors++; $display("FAIL abort_recover got done4=%b data=%h exp 1 c0df", log_done[4], ram[8'h41]);
        end
    endtask

    task automatic test_back_to_back;
        poke(8'h50, 16'hA050);
        poke(8'h51, 16'hA051);
        @(negedge clk);
        start = 1'b1; src = 9'h050; dst = 9'h060; len = 9'd1;
        @(posedge clk);
        #1 src = 9'h051; dst = 9'h061;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            log_cmd[c] = mem_cmd; log_addr[c] = mem_addr; log_done[c] = done; log_busy[c] = busy;
            if (c == 6) start = 1'b0;
        end
        checks++;
        if (log_addr[2] !== 9'h050 || log_done[4] !== 1'b1 || log_busy[5] !== 1'b0) begin
            errors++; $display("FAIL b2b_first got addr2=%h done4=%b busy5=%b exp 050 1 0",
                               log_addr[2], log_done[4], log_busy[5]);
        end
        checks++;
        if (log_cmd[6] !== 2'b01 || log_addr[6] !== 9'h051 || log_done[9] !== 1'b1 || log_busy[10] !== 1'b0) begin
            errors++; $display("FAIL b2b_second got %b/%h done9=%b busy10=%b exp 01/051 1 0",
                               log_cmd[6], log_addr[6], log_done[9], log_busy[10]);
        end
        checks++;
        if (ram[8'h60] !== 16'hA050 || ram[8'h61] !== 16'hA051) begin
            errors++; $display("FAIL b2b_data got %h %h exp a050 a051", ram[8'h60], ram[8'h61]);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0; sw = 8'h00; led = 8'h00;
        test_reset;
        test_copy3;
        test_len0;
        test_io;
        test_wrap;
        test_abort;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
